// File: rtl/blink_pkg.sv
// Types and constants shared by the button debouncer and the LED blinker.
package blink_pkg;

  localparam int CLK_FREQ_HZ             = 100_000_000;
  localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_FREQ_HZ / 100;  // 10 ms

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    PRESS_PENDING   = 2'd1,
    PRESSED         = 2'd2,
    RELEASE_PENDING = 2'd3
  } debounce_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Event bundle from the button debouncer (master) to the LED blinker (slave).
interface btn_debounce_if
  import blink_pkg::*;
#(
  parameter int RATE_W = 2
);
  // Pulses are single-cycle strobes with no back-pressure: there is no
  // valid/ready pair, so the consumer must sample them every clock.
  logic              btn_level;
  logic              press_pulse;
  logic              release_pulse;
  logic              long_press_pulse;
  logic [RATE_W-1:0] rate_sel;
  debounce_state_t   state;

  modport master (
    output btn_level, press_pulse, release_pulse, long_press_pulse, rate_sel, state
  );

  modport slave (
    input btn_level, press_pulse, release_pulse, long_press_pulse, rate_sel, state
  );
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs; both stages reset to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/btn_debounce.sv
// Pushbutton debouncer: sync, 4-state bounce filter, press/release pulses, blink-rate selector.
// Optional long-press detection is enabled by defining BTN_DEBOUNCE_LONG_PRESS_EN.
module btn_debounce
  import blink_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = 100_000_000,
  parameter int RATE_LEVELS       = 4
) (
  input  logic           clk_sys,
  input  logic           rst,
  input  logic           btn_raw,
  btn_debounce_if.master evt
);
  localparam int CNT_W  = $clog2(max_int(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES));
  localparam int RATE_W = $clog2(RATE_LEVELS);

  // The edge that enters a pending state is the first filter edge, so the
  // change is accepted when the counter already shows DEBOUNCE_CYCLES-2.
  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(RATE_LEVELS - 1);

  logic              btn_sync;
  debounce_state_t   state_q;
  logic [CNT_W-1:0]  db_cnt;
  logic              level_q;
  logic              press_q;
  logic              release_q;
  logic [RATE_W-1:0] rate_q;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  logic [CNT_W-1:0] hold_cnt;
  logic             long_done;
  logic             long_q;
`endif

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk (clk_sys),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_sync)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q   <= RELEASED;
      db_cnt    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      rate_q    <= '0;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
      hold_cnt  <= '0;
      long_done <= 1'b0;
      long_q    <= 1'b0;
`endif
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      unique case (state_q)
        RELEASED: begin
          if (btn_sync) begin
            state_q <= PRESS_PENDING;
            db_cnt  <= '0;
          end
        end
        PRESS_PENDING: begin
          if (!btn_sync) begin
            state_q <= RELEASED;
            db_cnt  <= '0;
          end else if (db_cnt == DB_LAST) begin
            state_q <= PRESSED;
            db_cnt  <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
            rate_q  <= (rate_q == RATE_LAST) ? '0 : rate_q + RATE_W'(1);
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
            hold_cnt  <= '0;
            long_done <= 1'b0;
`endif
          end else begin
            db_cnt <= db_cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!btn_sync) begin
            state_q <= RELEASE_PENDING;
            db_cnt  <= '0;
          end
        end
        RELEASE_PENDING: begin
          // A glitch back to 1 returns to PRESSED silently; hold time is kept.
          if (btn_sync) begin
            state_q <= PRESSED;
            db_cnt  <= '0;
          end else if (db_cnt == DB_LAST) begin
            state_q   <= RELEASED;
            db_cnt    <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            db_cnt <= db_cnt + CNT_W'(1);
          end
        end
        default: state_q <= RELEASED;
      endcase

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
      long_q <= 1'b0;
      if (state_q == PRESSED) begin
        if (hold_cnt != '1) hold_cnt <= hold_cnt + CNT_W'(1);
        // long_done keeps a saturated counter from re-firing within one press.
        if (hold_cnt == LONG_LAST && !long_done) begin
          long_q    <= 1'b1;
          long_done <= 1'b1;
          rate_q    <= '0;
        end
      end
`endif
    end
  end

  assign evt.btn_level     = level_q;
  assign evt.press_pulse   = press_q;
  assign evt.release_pulse = release_q;
  assign evt.rate_sel      = rate_q;
  assign evt.state         = state_q;
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  assign evt.long_press_pulse = long_q;
`else
  assign evt.long_press_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32, RATE_LEVELS=4.
module tb_btn_debounce;
  import blink_pkg::*;

  localparam int DB   = 8;
  localparam int LP   = 32;
  localparam int RL   = 4;
  localparam int RW   = 2;
  localparam int LAT  = DB + 2;

  logic clk;
  logic rst;
  logic btn_raw;

  btn_debounce_if #(.RATE_W(RW)) evt ();

  btn_debounce #(
    .DEBOUNCE_CYCLES   (DB),
    .LONG_PRESS_CYCLES (LP),
    .RATE_LEVELS       (RL)
  ) dut (
    .clk_sys (clk),
    .rst     (rst),
    .btn_raw (btn_raw),
    .evt     (evt)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- scoreboard ----
  int n_checks = 0;
  int n_pass   = 0;
  int press_seen   = 0;
  int release_seen = 0;
  int long_seen    = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Every press pulse must carry the next expected rate_sel value.
  always @(negedge clk) begin
    if (evt.press_pulse === 1'b1) begin
      press_seen++;
      if (exp_q.size() > 0) check("press_rate", 32'(evt.rate_sel), 32'(exp_q.pop_front()));
      else check("press_unexpected", 32'd1, 32'd0);
    end
    if (evt.release_pulse === 1'b1) release_seen++;
    if (evt.long_press_pulse === 1'b1) long_seen++;
  end

  // ---- driver tasks ----
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    step(n);
    rst = 1'b0;
  endtask

  task automatic press_release(input int hold, input int gap);
    btn_raw = 1'b1;
    step(hold);
    btn_raw = 1'b0;
    step(gap);
  endtask

  int p0, r0, l0;

  initial begin
    rst     = 1'b1;
    btn_raw = 1'b0;

    // Reset: outputs held at 0 during and after reset.
    step(1);
    check("rst_level",   32'(evt.btn_level), 0);
    check("rst_press",   32'(evt.press_pulse), 0);
    check("rst_release", 32'(evt.release_pulse), 0);
    check("rst_long",    32'(evt.long_press_pulse), 0);
    check("rst_rate",    32'(evt.rate_sel), 0);
    check("rst_state",   32'(evt.state), 32'(RELEASED));
    step(2);
    rst = 1'b0;
    step(1);
    check("post_rst_level", 32'(evt.btn_level), 0);
    check("post_rst_rate",  32'(evt.rate_sel), 0);

    // Clean press: level rises exactly LAT edges after the first sampling edge.
    exp_q.push_back(2'd1);
    btn_raw = 1'b1;
    step(LAT - 1);
    check("press_early_level", 32'(evt.btn_level), 0);
    check("press_pending",     32'(evt.state), 32'(PRESS_PENDING));
    step(1);
    check("press_level", 32'(evt.btn_level), 1);
    check("press_pulse", 32'(evt.press_pulse), 1);
    check("press_rate1", 32'(evt.rate_sel), 1);
    step(1);
    check("press_pulse_once", 32'(evt.press_pulse), 0);
    step(30 - LAT - 1);
    btn_raw = 1'b0;
    step(LAT - 1);
    check("release_early_level", 32'(evt.btn_level), 1);
    step(1);
    check("release_level", 32'(evt.btn_level), 0);
    check("release_pulse", 32'(evt.release_pulse), 1);
    step(1);
    check("release_pulse_once", 32'(evt.release_pulse), 0);
    step(4);

    // Bounce: toggling every 3 cycles is filtered out entirely.
    p0 = press_seen; r0 = release_seen;
    for (int i = 0; i < 10; i++) begin
      btn_raw = (i % 2 == 0);
      step(3);
      check("bounce_level", 32'(evt.btn_level), 0);
    end
    btn_raw = 1'b0;
    step(12);
    check("bounce_press_cnt",   32'(press_seen - p0), 0);
    check("bounce_release_cnt", 32'(release_seen - r0), 0);
    check("bounce_rate",        32'(evt.rate_sel), 1);

    // Wrap: from reset, four presses step rate_sel 1,2,3,0.
    do_reset(3);
    step(2);
    p0 = press_seen; r0 = release_seen;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(RW'(i % RL));
      press_release(LAT + 2, LAT + 2);
    end
    check("wrap_press_cnt",   32'(press_seen - p0), 4);
    check("wrap_release_cnt", 32'(release_seen - r0), 4);
    check("wrap_rate",        32'(evt.rate_sel), 0);

    // Long press: hold 50 cycles.
    do_reset(3);
    step(2);
    l0 = long_seen;
    exp_q.push_back(2'd1);
    btn_raw = 1'b1;
    step(LAT);
    check("long_level_up", 32'(evt.btn_level), 1);
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    step(LP - 1);
    check("long_early", 32'(evt.long_press_pulse), 0);
    step(1);
    check("long_pulse", 32'(evt.long_press_pulse), 1);
    check("long_rate0", 32'(evt.rate_sel), 0);
    step(1);
    check("long_once", 32'(evt.long_press_pulse), 0);
    step(50 - LAT - LP - 1);
    btn_raw = 1'b0;
    step(LAT + 2);
    check("long_count", 32'(long_seen - l0), 1);
    check("long_rate_after", 32'(evt.rate_sel), 0);
`else
    step(50 - LAT);
    btn_raw = 1'b0;
    step(LAT + 2);
    check("long_count_off", 32'(long_seen - l0), 0);
    check("long_rate_off",  32'(evt.rate_sel), 1);
`endif

    // Reset mid-press: level drops silently, then a fresh press follows.
    do_reset(3);
    step(2);
    exp_q.push_back(2'd1);
    btn_raw = 1'b1;
    step(LAT + 3);
    check("midrst_pressed", 32'(evt.btn_level), 1);
    r0 = release_seen;
    rst = 1'b1;
    step(1);
    check("midrst_level",   32'(evt.btn_level), 0);
    check("midrst_release", 32'(evt.release_pulse), 0);
    check("midrst_rate",    32'(evt.rate_sel), 0);
    step(2);
    exp_q.push_back(2'd1);
    rst = 1'b0;
    step(LAT - 1);
    check("midrst_early_level", 32'(evt.btn_level), 0);
    step(1);
    check("midrst_repress_level", 32'(evt.btn_level), 1);
    check("midrst_repress_pulse", 32'(evt.press_pulse), 1);
    check("midrst_no_release",    32'(release_seen - r0), 0);
    btn_raw = 1'b0;
    step(LAT + 2);

    check("exp_q_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
